// File: rtl/cdda_serializer.sv
// ============================================================================
//  Module   : cdda_serializer
//  Purpose  : Buffers stereo 16-bit PCM samples in a small FIFO and plays them
//             out as a 64-slot serial frame (MSB first, left then right) with
//             a bit clock (SCK) and channel select (LRCK) for the G1 connector.
//             Each frame is 64 bit slots of CLK_PER_BIT clock cycles. A frame
//             that finds the FIFO empty plays silence and records an underrun.
//  Ports    : io_DC_CDCLK      - sole clock (rising edge)
//             io_DC_RST        - synchronous active-high reset
//             io_EN            - enable serial output
//             io_SAMPLE_IN     - [31:16] left, [15:0] right, two's complement
//             io_SAMPLE_VALID  - push request
//             io_SAMPLE_READY  - FIFO not full (registered)
//             io_FIFO_LEVEL    - current FIFO occupancy
//             io_DC_SCK/SDAT/LRCK - serial bit clock, data, channel select
//             io_UNDERRUN      - sticky underrun flag
//             io_UNDERRUN_CLR  - clears flag and counter (wins over a set)
//             io_UNDERRUN_CNT  - saturating underrun count
//  Config   : `define CDDA_UNDERRUN_CNT_EN to build the underrun counter;
//             without it io_UNDERRUN_CNT is tied to zero.
//             CLK_PER_BIT must be even and >= 2; FIFO_DEPTH a power of 2, >= 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdda_serializer #(
    parameter int CLK_PER_BIT = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          io_DC_CDCLK,
    input  logic                          io_DC_RST,
    input  logic                          io_EN,
    input  logic [31:0]                   io_SAMPLE_IN,
    input  logic                          io_SAMPLE_VALID,
    output logic                          io_SAMPLE_READY,
    output logic [$clog2(FIFO_DEPTH):0]   io_FIFO_LEVEL,
    output logic                          io_DC_SCK,
    output logic                          io_DC_SDAT,
    output logic                          io_DC_LRCK,
    output logic                          io_UNDERRUN,
    input  logic                          io_UNDERRUN_CLR,
    output logic [7:0]                    io_UNDERRUN_CNT
);

    localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] c_CNT_MAX  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLK_PER_BIT / 2);
    localparam logic [LW-1:0] c_DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [5:0]    c_SLOT_MAX = 6'd63;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [5:0]      r_slot;
    logic [31:0]     r_frame;
    logic            r_sck;
    logic            r_sdat;
    logic            r_lrck;
    logic            r_underrun;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_ready;

    // ------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------
    state_t          w_state_nxt;
    logic            w_cnt_wrap;
    logic            w_frame_end;
    logic            w_load;
    logic [CW-1:0]   w_cnt_nxt;
    logic [5:0]      w_slot_nxt;
    logic [31:0]     w_frame_nxt;
    logic            w_sck_nxt;
    logic            w_sdat_nxt;
    logic            w_lrck_nxt;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_underrun_set;
    logic [LW-1:0]   w_level_nxt;

    assign w_empty        = (r_level == '0);
    assign w_push         = io_SAMPLE_VALID & r_ready;
    assign w_pop          = w_load & ~w_empty;
    assign w_underrun_set = w_load & w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cnt_wrap  = (r_cnt == c_CNT_MAX);
        w_frame_end = (r_state == S_RUN) && w_cnt_wrap && (r_slot == c_SLOT_MAX);

        case (r_state)
            S_IDLE: begin
                if (io_EN) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                // A frame, once started, always runs to the end of slot 63.
                if (w_frame_end) begin
                    if (io_EN) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt  = '0;
        w_slot_nxt = '0;
        if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
            w_cnt_nxt  = w_cnt_wrap ? '0 : (r_cnt + CW'(1));
            w_slot_nxt = w_cnt_wrap ? (r_slot + 6'd1) : r_slot;
        end
    end

    always_comb begin
        w_frame_nxt = r_frame;
        if (w_load) begin
            w_frame_nxt = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
        end
    end

    // Serial outputs are computed from next-cycle position so the registered
    // pins line up exactly with cnt/slot: a new slot's data and SCK's falling
    // edge both appear on the cycle where cnt becomes 0.
    // Slot n (0-15) carries left[15-n] = frame[31-n]; slot 32+n carries
    // right[15-n] = frame[15-n]. Both reduce to index {~slot[5], ~slot[3:0]};
    // slots with slot[4] set are padding.
    always_comb begin
        w_sck_nxt  = 1'b0;
        w_sdat_nxt = 1'b0;
        w_lrck_nxt = 1'b0;
        if (w_state_nxt == S_RUN) begin
            w_sck_nxt  = (w_cnt_nxt >= c_CNT_HALF);
            w_lrck_nxt = w_slot_nxt[5];
            if (!w_slot_nxt[4]) begin
                w_sdat_nxt = w_frame_nxt[{~w_slot_nxt[5], ~w_slot_nxt[3:0]}];
            end
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge io_DC_CDCLK) begin
        if (io_DC_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge io_DC_CDCLK) begin
        if (io_DC_RST) begin
            r_cnt   <= '0;
            r_slot  <= '0;
            r_frame <= '0;
            r_sck   <= 1'b0;
            r_sdat  <= 1'b0;
            r_lrck  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_slot  <= w_slot_nxt;
            r_frame <= w_frame_nxt;
            r_sck   <= w_sck_nxt;
            r_sdat  <= w_sdat_nxt;
            r_lrck  <= w_lrck_nxt;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge io_DC_CDCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_SAMPLE_IN;
        end
    end

    always_ff @(posedge io_DC_CDCLK) begin
        if (io_DC_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt < c_DEPTH);
        end
    end

    always_ff @(posedge io_DC_CDCLK) begin
        if (io_DC_RST) begin
            r_underrun <= 1'b0;
        end else if (io_UNDERRUN_CLR) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end
    end

`ifdef CDDA_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge io_DC_CDCLK) begin
        if (io_DC_RST) begin
            r_underrun_cnt <= '0;
        end else if (io_UNDERRUN_CLR) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun_set && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign io_UNDERRUN_CNT = r_underrun_cnt;
`else
    assign io_UNDERRUN_CNT = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_SAMPLE_READY = r_ready;
    assign io_FIFO_LEVEL   = r_level;
    assign io_DC_SCK       = r_sck;
    assign io_DC_SDAT      = r_sdat;
    assign io_DC_LRCK      = r_lrck;
    assign io_UNDERRUN     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_cdda_serializer.sv
// ============================================================================
//  Module   : tb_cdda_serializer
//  Purpose  : Self-checking bench for cdda_serializer. A frame-level reference
//             model (sample queue + position within frame) predicts FIFO
//             status, underrun state and pin levels; every frame it starts is
//             queued, and a monitor deserializes SCK/SDAT and compares each
//             completed 64-slot frame against the queue head.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cdda_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 64 * CPB;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   din = 32'h0;

    logic          ready;
    logic [LW-1:0] level;
    logic          sck;
    logic          sdat;
    logic          lrck;
    logic          unf;
    logic [7:0]    ucnt;

    always #5 clk = ~clk;

    cdda_serializer #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .io_DC_CDCLK     (clk),
        .io_DC_RST       (rst),
        .io_EN           (en),
        .io_SAMPLE_IN    (din),
        .io_SAMPLE_VALID (valid),
        .io_SAMPLE_READY (ready),
        .io_FIFO_LEVEL   (level),
        .io_DC_SCK       (sck),
        .io_DC_SDAT      (sdat),
        .io_DC_LRCK      (lrck),
        .io_UNDERRUN     (unf),
        .io_UNDERRUN_CLR (clr),
        .io_UNDERRUN_CNT (ucnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, evaluated on the same edges the DUT samples.
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    bit          m_run = 0;
    int          m_ph = 0;
    logic [31:0] m_cur = 0;
    bit          m_unf = 0;
    int          m_ucnt = 0;
    bit          m_ready = 0;
    bit          m_rst_seen = 1;
    bit          m_load, m_endf, m_push;
    logic [31:0] m_fr;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_run = 0; m_ph = 0; m_cur = 0;
            m_unf = 0; m_ucnt = 0; m_ready = 0;
            m_rst_seen = 1;
        end else begin
            m_rst_seen = 0;
            m_push = valid && m_ready;
            m_endf = m_run && (m_ph == FRAME - 1);
            m_load = en && (!m_run || m_endf);
            if (m_load) begin
                if (m_q.size() != 0) begin
                    m_fr = m_q.pop_front();
                end else begin
                    m_fr = 32'h0;
                    m_unf = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
                m_cur = m_fr;
                exp_q.push_back(m_fr);
            end
            if (clr) begin
                m_unf = 0;
                m_ucnt = 0;
            end
            if (m_push) m_q.push_back(din);
            if (!m_run) begin
                if (en) begin m_run = 1; m_ph = 0; end
            end else if (m_endf) begin
                m_ph = 0;
                if (!en) m_run = 0;
            end else begin
                m_ph++;
            end
            m_ready = (m_q.size() < DEPTH);
        end
    end

    function automatic int exp_cnt();
`ifdef CDDA_UNDERRUN_CNT_EN
        return m_ucnt;
`else
        return 0;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Monitor: per-cycle pin/status checks plus frame deserializer.
    // ------------------------------------------------------------------
    int          mon_slot = 0;
    bit          mon_prev = 0;
    logic [63:0] mon_bits = '0;

    always @(negedge clk) begin
        int s;
        logic e_sck, e_lrck, e_sdat;
        logic [15:0] lft, rgt;
        logic [31:0] ef;
        logic [63:0] pad;
        s = m_ph / CPB;
        e_sck = 0; e_lrck = 0; e_sdat = 0;
        if (m_run) begin
            e_sck  = (m_ph % CPB) >= (CPB / 2);
            e_lrck = (s >= 32);
            if (s < 16)                  e_sdat = m_cur[31 - s];
            else if (s >= 32 && s < 48)  e_sdat = m_cur[15 - (s - 32)];
        end
        chk("pins_sck_lrck_sdat", {sck, lrck, sdat}, {e_sck, e_lrck, e_sdat});
        chk("fifo_level", level, m_q.size());
        chk("sample_ready", ready, m_ready);
        chk("underrun_flag", unf, m_unf);
        chk("underrun_cnt", ucnt, exp_cnt());

        if (m_rst_seen) begin
            mon_slot = 0;
            mon_prev = 0;
        end else begin
            if (sck && !mon_prev) begin
                mon_bits[mon_slot] = sdat;
                mon_slot++;
                if (mon_slot == 64) begin
                    mon_slot = 0;
                    pad = mon_bits;
                    for (int n = 0; n < 16; n++) begin
                        lft[15 - n] = mon_bits[n];
                        rgt[15 - n] = mon_bits[32 + n];
                        pad[n] = 1'b0;
                        pad[32 + n] = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected: got frame %h with no expected frame queued", {lft, rgt});
                    end else begin
                        ef = exp_q.pop_front();
                        chk("frame_data", {lft, rgt}, ef);
                        chk("frame_padding", pad, 64'h0);
                    end
                end
            end
            mon_prev = sck;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; valid = 0; clr = 0;
        tick(2);
        rst = 0;
        tick(1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (!m_run) return;
            tick(1);
        end
        checks++;
        failures++;
        $display("FAIL wait_idle: got still running expected idle within %0d cycles", 3 * FRAME);
    endtask

    initial begin
        logic [63:0] ones;
        logic [63:0] ones_exp;
        int          rise_at;

        // Reset state and first cycle after release
        rst = 1;
        tick(3);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_level", level, 0);
        chk("rst_pins", {sck, sdat, lrck, unf}, 0);
        chk("rst_ucnt", ucnt, 0);
        rst = 0;
        tick(1);
        @(negedge clk);
        chk("ready_after_rst", ready, 1);

        // Five pushes while disabled: four accepted, fifth dropped
        valid = 1;
        for (int i = 0; i < 5; i++) begin
            din = 32'h1111_0000 + i * 32'h0101_0101;
            tick(1);
        end
        valid = 0;
        @(negedge clk);
        chk("full_level", level, 4);
        chk("full_ready", ready, 0);
        en = 1;
        tick(5 * FRAME + 10);
        en = 0;
        wait_idle();

        // Known pattern, LRCK rise position, drop enable at slot 10
        do_reset();
        din = 32'h8001_0003; valid = 1;
        tick(1);
        valid = 0; en = 1;
        tick(1);
        ones = '0; rise_at = -1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k % CPB == 0) ones[k / CPB] = sdat;
            if (lrck && rise_at < 0) rise_at = k;
            if (k == 10 * CPB) en = 0;
        end
        ones_exp = '0;
        ones_exp[0] = 1; ones_exp[15] = 1; ones_exp[46] = 1; ones_exp[47] = 1;
        chk("pattern_slots", ones, ones_exp);
        chk("lrck_rise_cycle", rise_at, 32 * CPB);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_after_drop", {sck, lrck, sdat}, 0);
        end

        // Underrun on empty FIFO; clear colliding with the next underrun
        do_reset();
        en = 1;
        tick(1);
        @(negedge clk);
        chk("first_underrun_flag", unf, 1);
        chk("first_underrun_cnt", ucnt, exp_cnt());
        tick(FRAME - 1);
        clr = 1;
        tick(1);
        clr = 0;
        @(negedge clk);
        chk("clr_priority_flag", unf, 0);
        chk("clr_priority_cnt", ucnt, 0);
        tick(FRAME);
        @(negedge clk);
        chk("underrun_after_clr", unf, 1);

        // Saturation after more than 255 consecutive underruns
        tick(258 * FRAME);
        @(negedge clk);
`ifdef CDDA_UNDERRUN_CNT_EN
        chk("underrun_saturate", ucnt, 255);
`else
        chk("underrun_cnt_absent", ucnt, 0);
`endif
        en = 0;
        wait_idle();

        // Reset mid-frame with samples queued
        do_reset();
        valid = 1;
        for (int i = 0; i < 4; i++) begin
            din = $urandom;
            tick(1);
        end
        valid = 0; en = 1;
        for (int i = 0; i < 2 * FRAME && !(m_run && m_ph == 40 * CPB); i++) tick(1);
        @(negedge clk);
        chk("queued_before_rst", level, 3);
        rst = 1;
        tick(1);
        @(negedge clk);
        chk("midframe_rst_pins", {sck, sdat, lrck}, 0);
        chk("midframe_rst_level", level, 0);
        rst = 0; en = 0;
        tick(1);

        // Randomized traffic
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            valid = ($urandom_range(0, 47) == 0);
            din   = $urandom;
            clr   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 399) == 0) en = ~en;
            tick(1);
        end
        valid = 0; clr = 0; en = 0;
        wait_idle();
        tick(2);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdda_serializer.md
CDDA_SERIALIZER -- requirements
Module: cdda_serializer

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 6, io_DC_CDCLK cycles per bit slot; even, >=2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample FIFO entries; power of 2.
REQ-003 io_DC_CDCLK  in  1  sole clock; all logic on its rising edge.
REQ-004 io_DC_RST  in  1  reset; synchronous, active-high.
REQ-005 io_EN  in  1  enable serial output; sampled each cycle.
REQ-006 io_SAMPLE_IN  in  32  stereo PCM; [31:16] left, [15:0] right, two's complement.
REQ-007 io_SAMPLE_VALID  in  1  push request.
REQ-008 io_SAMPLE_READY  out  1  FIFO not full; push accepted when VALID&READY.
REQ-009 io_FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-010 io_DC_SCK  out  1  bit clock to G1 connector.
REQ-011 io_DC_SDAT  out  1  serial data, MSB first.
REQ-012 io_DC_LRCK  out  1  channel select; 0 = left, 1 = right.
REQ-013 io_UNDERRUN  out  1  sticky underrun flag.
REQ-014 io_UNDERRUN_CLR  in  1  clears io_UNDERRUN.
REQ-015 io_UNDERRUN_CNT  out  8  underrun count (see Configuration).

Function
REQ-016 SHALL implement FSM {IDLE, RUN}; IDLE->RUN when io_EN=1; RUN->IDLE only at end of slot 63 when io_EN=0 (current frame always completes).
REQ-017 Divider cnt SHALL count 0..CLK_PER_BIT-1 in RUN, held 0 in IDLE; SCK=0 for cnt<CLK_PER_BIT/2, else 1.
REQ-018 Slot counter SHALL count 0..63, advance on cnt wrap, wrap 63->0; frame = 64*CLK_PER_BIT cycles (384 default).
REQ-019 LRCK SHALL be 0 for slots 0-31, 1 for slots 32-63.
REQ-020 SDAT slot n (0-15) = left[15-n]; slot 32+n (0-15) = right[15-n]; slots 16-31, 48-63 = 0.
REQ-021 SCK, SDAT, LRCK SHALL be registered and change only on cycles where cnt==0 (SCK falling edge); stable while SCK=1.
REQ-022 Frame load SHALL occur on IDLE->RUN transition cycle and on cycle cnt==CLK_PER_BIT-1, slot==63 while staying RUN; pops FIFO head if not empty.
REQ-023 Frame load with FIFO empty SHALL load 0x0000_0000, set io_UNDERRUN, and increment io_UNDERRUN_CNT (saturating at 255).
REQ-024 io_UNDERRUN_CLR SHALL take priority over simultaneous set; flag and counter both cleared.
REQ-025 io_SAMPLE_READY SHALL equal (level < FIFO_DEPTH) registered; push on full cycle ignored even if pop same cycle.
REQ-026 Simultaneous push and pop SHALL leave level unchanged; FIFO order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-027 In IDLE: SCK=0, SDAT=0, LRCK=0; FIFO accepts pushes; no underruns counted.
REQ-028 First SCK falling edge (cnt==0, slot 0) SHALL appear 1 cycle after frame load; latency push-into-empty to SDAT slot 0 <= 1 frame + 2 cycles.

Reset
REQ-029 On io_DC_RST=1: FSM=IDLE, cnt=0, slot=0, FIFO empty, io_FIFO_LEVEL=0, SCK=SDAT=LRCK=0, io_UNDERRUN=0, io_UNDERRUN_CNT=0, io_SAMPLE_READY=0.
REQ-030 io_SAMPLE_READY SHALL be 1 on first cycle after reset release.
REQ-031 Reset mid-frame SHALL abort immediately; queued samples discarded.

Configuration
REQ-032 Macro CDDA_UNDERRUN_CNT_EN defined: 8-bit saturating counter per REQ-023/024.
REQ-033 Macro undefined: counter logic absent, io_UNDERRUN_CNT tied 0; io_UNDERRUN flag unaffected.

Verification
REQ-034 Push 0x8001_0003, assert io_EN -> slots 0,15,46,47 SDAT=1, all others 0; LRCK rises at cycle 192 of frame.
REQ-035 Push 5 samples with io_EN=0 -> 4 accepted, READY=0 after 4th, FIFO_LEVEL=4; 5th dropped.
REQ-036 io_EN=1 with empty FIFO -> SDAT=0 all frame, io_UNDERRUN=1, CNT=1; UNDERRUN_CLR same cycle as next underrun -> both 0.
REQ-037 Drop io_EN at slot 10 -> frame finishes to slot 63, then SCK/LRCK/SDAT=0, FSM IDLE.
REQ-038 300 consecutive underruns -> io_UNDERRUN_CNT=255 (macro defined) / 0 (undefined).
REQ-039 io_DC_RST asserted at slot 40 with 3 queued -> next cycle all outputs 0, FIFO_LEVEL=0.
